// File: rtl/seg7_serial_driver_pkg.sv
// Shared definitions for the 7-segment serial driver: FSM encoding, digit
// geometry and the bit-counter width helper.
package seg7_serial_driver_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT_LO = 2'd1,
        SHIFT_HI = 2'd2,
        LATCH    = 2'd3
    } state_t;

    localparam int SEG_BITS       = 7;
    localparam int BITS_PER_DIGIT = 8;

    // Width needed to count down from num_digits*8-1 (at least 3 for one digit).
    function automatic int bitcnt_w(input int num_digits);
        return $clog2(num_digits * BITS_PER_DIGIT);
    endfunction

endpackage

// File: rtl/seg7_phase_timer.sv
// Phase-length down-counter: reloaded with CLK_DIV-1 on each FSM state entry,
// phase_end is high during the last cycle of the phase.
module seg7_phase_timer #(
    parameter int CLK_DIV = 2
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_reload,
    output logic o_phase_end
);

    localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [W-1:0] cnt;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cnt <= '0;
        end else if (i_reload) begin
            cnt <= W'(CLK_DIV - 1);
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign o_phase_end = (cnt == '0);

endmodule

// File: rtl/seg7_serial_driver.sv
// Serialises NUM_DIGITS segment bytes {abcdefg,dp} onto a 74HC595 chain and
// latches them. Define SEG7_ACTIVE_LOW_EN to invert the frame for common-anode parts.
module seg7_serial_driver
    import seg7_serial_driver_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int CLK_DIV    = 2
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_start,
    input  logic [SEG_BITS*NUM_DIGITS-1:0] i_segs,
    input  logic [NUM_DIGITS-1:0]        i_dp,
    input  logic                         i_blank,
    output logic                         o_serial_data,
    output logic                         o_serial_clk,
    output logic                         o_latch,
    output logic                         o_busy,
    output logic                         o_done
);

    localparam int FRAME_BITS = NUM_DIGITS * BITS_PER_DIGIT;
    localparam int CNT_W      = bitcnt_w(NUM_DIGITS);

    state_t                 state, state_n;
    logic [CNT_W-1:0]       bitcnt;
    logic [CNT_W-1:0]       bit_prev;
    logic [FRAME_BITS-1:0]  snap;
    logic [FRAME_BITS-1:0]  frame_raw;
    logic [FRAME_BITS-1:0]  snap_next;
    logic                   phase_end;
    logic                   accept;
    logic                   reload;

    // Digit k lands at frame[8k+7:8k], so counting the index down from the top
    // sends the leftmost digit first, segment a leading.
    always_comb begin
        frame_raw = '0;
        if (!i_blank) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                frame_raw[k*BITS_PER_DIGIT +: BITS_PER_DIGIT] =
                    {i_segs[k*SEG_BITS +: SEG_BITS], i_dp[k]};
            end
        end
    end

`ifdef SEG7_ACTIVE_LOW_EN
    assign snap_next = ~frame_raw;
`else
    assign snap_next = frame_raw;
`endif

    assign accept   = (state == IDLE) && i_start;
    assign reload   = (state_n != state);
    assign bit_prev = bitcnt - 1'b1;

    seg7_phase_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_timer (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_reload    (reload),
        .o_phase_end (phase_end)
    );

    always_comb begin
        state_n = state;
        case (state)
            IDLE:     if (i_start)   state_n = SHIFT_LO;
            SHIFT_LO: if (phase_end) state_n = SHIFT_HI;
            SHIFT_HI: if (phase_end) state_n = (bitcnt == '0) ? LATCH : SHIFT_LO;
            LATCH:    if (phase_end) state_n = IDLE;
            default:                 state_n = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they align with the state register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state         <= IDLE;
            bitcnt        <= '0;
            snap          <= '0;
            o_serial_data <= 1'b0;
            o_serial_clk  <= 1'b0;
            o_latch       <= 1'b0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
        end else begin
            state        <= state_n;
            o_busy       <= (state_n != IDLE);
            o_serial_clk <= (state_n == SHIFT_HI);
            o_latch      <= (state_n == LATCH);
            o_done       <= (state == LATCH) && (state_n == IDLE);
            if (accept) begin
                snap          <= snap_next;
                bitcnt        <= CNT_W'(FRAME_BITS - 1);
                o_serial_data <= snap_next[FRAME_BITS-1];
            end else if ((state == SHIFT_HI) && phase_end) begin
                if (bitcnt == '0) begin
                    o_serial_data <= 1'b0;
                end else begin
                    bitcnt        <= bit_prev;
                    o_serial_data <= snap[bit_prev];
                end
            end
        end
    end

endmodule
